// File: rtl/parity_check_stream_pkg.sv
// Shared types, default sizes and the width-generic parity verdict used by
// the parity_check_stream slice.
package parity_pkg;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } parity_mode_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 16;
    localparam int MAX_DATA_W = 64;

    // Callers zero-extend narrower words; the extra zeros do not change the XOR.
    function automatic logic parity_ok(input logic [MAX_DATA_W-1:0] data,
                                       input logic                  parity,
                                       input parity_mode_e          mode);
        return ((^data) ^ parity) == logic'(mode);
    endfunction

endpackage

// File: rtl/parity_check_stream_if.sv
// Receive-side and delivery-side stream signals of the parity checker.
// master = the environment around the checker, slave = the checker itself.
interface parity_check_stream_if
    import parity_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_parity;
    logic              odd_mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_parity_ok;

    modport master (
        output in_valid, in_data, in_parity, odd_mode, out_ready,
        input  in_ready, out_valid, out_data, out_parity_ok
    );

    modport slave (
        input  in_valid, in_data, in_parity, odd_mode, out_ready,
        output in_ready, out_valid, out_data, out_parity_ok
    );

endinterface

// File: rtl/parity_check_stream_stat_cnt.sv
// Saturating statistics counter; a clear coinciding with an increment
// leaves the counter at 1 so the word in flight is not lost.
module parity_stat_cnt
    import parity_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/parity_check_stream.sv
// Streaming parity checker with one output register stage and statistics.
// Optional macro PARITY_CHECK_DROP_ERR_EN: failing words are consumed, never presented.
module parity_check_stream
    import parity_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    parity_check_stream_if.slave   bus,
    input  logic                   clr_stats,
    output logic                   err_sticky,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [CNT_W-1:0]       word_cnt
);

    // Handshake: a word moves when valid && ready on the same rising edge;
    // valid never waits on ready, and a presented word stays stable until taken.
    logic                  accept;
    logic                  word_ok;
    logic                  present;
    logic [MAX_DATA_W-1:0] data_ext;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        data_ext               = '0;
        data_ext[DATA_W-1:0]   = bus.in_data;
    end

    assign word_ok = parity_ok(data_ext, bus.in_parity, parity_mode_e'(bus.odd_mode));

`ifdef PARITY_CHECK_DROP_ERR_EN
    assign present = word_ok;
`else
    assign present = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid     <= 1'b0;
            bus.out_data      <= '0;
            bus.out_parity_ok <= 1'b0;
        end else if (accept) begin
            bus.out_valid     <= present;
            bus.out_data      <= bus.in_data;
            bus.out_parity_ok <= word_ok;
        end else if (bus.out_ready) begin
            bus.out_valid     <= 1'b0;
        end
    end

    // Clear wins over set, but an errored word accepted with the clear re-arms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (clr_stats) begin
            err_sticky <= accept && !word_ok;
        end else if (accept && !word_ok) begin
            err_sticky <= 1'b1;
        end
    end

    parity_stat_cnt #(.CNT_W(CNT_W)) u_word_cnt (
        .clk (clk),
        .rst (rst),
        .inc (accept),
        .clr (clr_stats),
        .cnt (word_cnt)
    );

    parity_stat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (accept && !word_ok),
        .clr (clr_stats),
        .cnt (err_cnt)
    );

endmodule

// File: tb/tb_parity_check_stream.sv
// Directed bench for parity_check_stream: a default-size instance plus a
// CNT_W=3 instance for saturation. Honours PARITY_CHECK_DROP_ERR_EN.
module tb_parity_check_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_stats, s_clr_stats;
    logic        err_sticky, s_err_sticky;
    logic [15:0] err_cnt, word_cnt;
    logic [2:0]  s_err_cnt, s_word_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    parity_check_stream_if #(.DATA_W(8)) bus ();
    parity_check_stream_if #(.DATA_W(8)) sbus ();

    parity_check_stream #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus), .clr_stats(clr_stats),
        .err_sticky(err_sticky), .err_cnt(err_cnt), .word_cnt(word_cnt)
    );

    parity_check_stream #(.DATA_W(8), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .bus(sbus), .clr_stats(s_clr_stats),
        .err_sticky(s_err_sticky), .err_cnt(s_err_cnt), .word_cnt(s_word_cnt)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        clr_stats = 1'b0; s_clr_stats = 1'b0;
        bus.in_valid = 1'b0;  bus.in_data = '0;  bus.in_parity = 1'b0;
        bus.odd_mode = 1'b0;  bus.out_ready = 1'b1;
        sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.in_parity = 1'b0;
        sbus.odd_mode = 1'b0; sbus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", bus.out_data); end
        n_checks++; if (bus.out_parity_ok !== 1'b0) begin n_fail++; $display("FAIL reset_ok: got %b expected 0", bus.out_parity_ok); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        n_checks++; if ({err_sticky, err_cnt, word_cnt} !== 33'd0) begin n_fail++; $display("FAIL reset_stats: sticky=%b err=%0d words=%0d expected 0 0 0", err_sticky, err_cnt, word_cnt); end
    endtask

    task automatic test_even();
        do_reset();
        bus.odd_mode = 1'b0; bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.in_parity = 1'b0;
        @(negedge clk);
        n_checks++; if ({bus.out_valid, bus.out_parity_ok, bus.out_data} !== {2'b11, 8'hA5}) begin n_fail++; $display("FAIL even_good: valid=%b ok=%b data=%h expected 1 1 a5", bus.out_valid, bus.out_parity_ok, bus.out_data); end
        bus.in_parity = 1'b1;
        @(negedge clk);
`ifdef PARITY_CHECK_DROP_ERR_EN
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL even_bad_dropped: valid=%b expected 0", bus.out_valid); end
`else
        n_checks++; if ({bus.out_valid, bus.out_parity_ok, bus.out_data} !== {2'b10, 8'hA5}) begin n_fail++; $display("FAIL even_bad: valid=%b ok=%b data=%h expected 1 0 a5", bus.out_valid, bus.out_parity_ok, bus.out_data); end
`endif
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL even_drain: valid=%b expected 0", bus.out_valid); end
        n_checks++; if ({err_sticky, err_cnt, word_cnt} !== {1'b1, 16'd1, 16'd2}) begin n_fail++; $display("FAIL even_stats: sticky=%b err=%0d words=%0d expected 1 1 2", err_sticky, err_cnt, word_cnt); end
    endtask

    task automatic test_odd();
        do_reset();
        bus.odd_mode = 1'b1; bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'h01; bus.in_parity = 1'b0;
        @(negedge clk);
        n_checks++; if ({bus.out_valid, bus.out_parity_ok, bus.out_data} !== {2'b11, 8'h01}) begin n_fail++; $display("FAIL odd_good: valid=%b ok=%b data=%h expected 1 1 01", bus.out_valid, bus.out_parity_ok, bus.out_data); end
        bus.in_data = 8'h03;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.odd_mode = 1'b0;
`ifdef PARITY_CHECK_DROP_ERR_EN
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL odd_bad_dropped: valid=%b expected 0", bus.out_valid); end
`else
        n_checks++; if ({bus.out_valid, bus.out_parity_ok, bus.out_data} !== {2'b10, 8'h03}) begin n_fail++; $display("FAIL odd_bad: valid=%b ok=%b data=%h expected 1 0 03", bus.out_valid, bus.out_parity_ok, bus.out_data); end
        // mode flip while the word is held must not re-evaluate its verdict
        @(negedge clk);
        n_checks++; if ({bus.out_valid, bus.out_parity_ok} !== 2'b10) begin n_fail++; $display("FAIL odd_held_verdict: valid=%b ok=%b expected 1 0", bus.out_valid, bus.out_parity_ok); end
`endif
        n_checks++; if ({err_sticky, err_cnt, word_cnt} !== {1'b1, 16'd1, 16'd2}) begin n_fail++; $display("FAIL odd_stats: sticky=%b err=%0d words=%0d expected 1 1 2", err_sticky, err_cnt, word_cnt); end
    endtask

    task automatic test_backpressure();
        logic [7:0] data_tbl [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] exp_q [$];
        int   idx = 0;
        int   delivered = 0;
        int   cyc = 0;
        logic exp_rdy;
        do_reset();
        bus.odd_mode = 1'b0; bus.in_parity = 1'b0;
        while ((idx < 4 || exp_q.size() != 0) && cyc < 60) begin
            bus.out_ready = !(cyc >= 1 && cyc <= 5);
            bus.in_valid  = (idx < 4);
            bus.in_data   = (idx < 4) ? data_tbl[idx] : 8'h00;
            #1;
            exp_rdy = (exp_q.size() == 0) || bus.out_ready;
            n_checks++; if (bus.in_ready !== exp_rdy) begin n_fail++; $display("FAIL bp_in_ready cyc %0d: got %b expected %b", cyc, bus.in_ready, exp_rdy); end
            if (exp_q.size() != 0) begin
                n_checks++; if ({bus.out_valid, bus.out_data} !== {1'b1, exp_q[0]}) begin n_fail++; $display("FAIL bp_out cyc %0d: valid=%b data=%h expected 1 %h", cyc, bus.out_valid, bus.out_data, exp_q[0]); end
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    delivered++;
                end
            end else begin
                n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle cyc %0d: valid=%b expected 0", cyc, bus.out_valid); end
            end
            if (bus.in_valid && exp_rdy) begin
                exp_q.push_back(bus.in_data);
                idx++;
            end
            cyc++;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        n_checks++; if (cyc >= 60) begin n_fail++; $display("FAIL bp_timeout: cycles=%0d expected < 60", cyc); end
        n_checks++; if (delivered != 4) begin n_fail++; $display("FAIL bp_delivered: got %0d expected 4", delivered); end
        n_checks++; if (word_cnt !== 16'd4) begin n_fail++; $display("FAIL bp_word_cnt: got %0d expected 4", word_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        sbus.out_ready = 1'b1; sbus.odd_mode = 1'b0;
        sbus.in_valid = 1'b1; sbus.in_data = 8'hA5; sbus.in_parity = 1'b1;
        repeat (10) @(negedge clk);
        sbus.in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (s_err_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_err_cnt: got %0d expected 7", s_err_cnt); end
        n_checks++; if (s_word_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_word_cnt: got %0d expected 7", s_word_cnt); end
        n_checks++; if (s_err_sticky !== 1'b1) begin n_fail++; $display("FAIL sat_sticky: got %b expected 1", s_err_sticky); end
        s_clr_stats = 1'b1;
        @(negedge clk);
        s_clr_stats = 1'b0;
        n_checks++; if ({s_err_sticky, s_err_cnt, s_word_cnt} !== 7'd0) begin n_fail++; $display("FAIL sat_clear: sticky=%b err=%0d words=%0d expected 0 0 0", s_err_sticky, s_err_cnt, s_word_cnt); end
    endtask

    task automatic test_clr_coincident();
        do_reset();
        bus.out_ready = 1'b1; bus.odd_mode = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.in_parity = 1'b1;
        @(negedge clk);
        bus.in_parity = 1'b0; clr_stats = 1'b1;
        @(negedge clk);
        n_checks++; if ({err_sticky, err_cnt, word_cnt} !== {1'b0, 16'd0, 16'd1}) begin n_fail++; $display("FAIL clr_good: sticky=%b err=%0d words=%0d expected 0 0 1", err_sticky, err_cnt, word_cnt); end
        bus.in_parity = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; clr_stats = 1'b0;
        n_checks++; if ({err_sticky, err_cnt, word_cnt} !== {1'b1, 16'd1, 16'd1}) begin n_fail++; $display("FAIL clr_bad: sticky=%b err=%0d words=%0d expected 1 1 1", err_sticky, err_cnt, word_cnt); end
        @(negedge clk);
        n_checks++; if ({err_sticky, err_cnt, word_cnt} !== {1'b1, 16'd1, 16'd1}) begin n_fail++; $display("FAIL clr_idle: sticky=%b err=%0d words=%0d expected 1 1 1", err_sticky, err_cnt, word_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.out_ready = 1'b0; bus.odd_mode = 1'b0;
        bus.in_valid = 1'b1; bus.in_data = 8'h5A; bus.in_parity = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_checks++; if ({bus.out_valid, bus.in_ready, bus.out_data} !== {2'b10, 8'h5A}) begin n_fail++; $display("FAIL rmid_held: valid=%b in_ready=%b data=%h expected 1 0 5a", bus.out_valid, bus.in_ready, bus.out_data); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if ({bus.out_valid, bus.out_parity_ok, bus.out_data} !== 10'd0) begin n_fail++; $display("FAIL rmid_out: valid=%b ok=%b data=%h expected 0 0 00", bus.out_valid, bus.out_parity_ok, bus.out_data); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b expected 1", bus.in_ready); end
        n_checks++; if ({err_sticky, err_cnt, word_cnt} !== 33'd0) begin n_fail++; $display("FAIL rmid_stats: sticky=%b err=%0d words=%0d expected 0 0 0", err_sticky, err_cnt, word_cnt); end
    endtask

`ifdef PARITY_CHECK_DROP_ERR_EN
    task automatic test_drop();
        logic [7:0] data_tbl [3] = '{8'hA5, 8'hA5, 8'h3C};
        logic       par_tbl  [3] = '{1'b0, 1'b1, 1'b0};
        int beats = 0;
        do_reset();
        bus.out_ready = 1'b1; bus.odd_mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid  = (i < 3);
            bus.in_data   = (i < 3) ? data_tbl[i] : 8'h00;
            bus.in_parity = (i < 3) ? par_tbl[i] : 1'b0;
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                beats++;
                n_checks++; if (bus.out_parity_ok !== 1'b1) begin n_fail++; $display("FAIL drop_ok beat %0d: got %b expected 1", beats, bus.out_parity_ok); end
            end
        end
        n_checks++; if (beats != 2) begin n_fail++; $display("FAIL drop_beats: got %0d expected 2", beats); end
        n_checks++; if ({err_cnt, word_cnt} !== {16'd1, 16'd3}) begin n_fail++; $display("FAIL drop_stats: err=%0d words=%0d expected 1 3", err_cnt, word_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_even();
        test_odd();
        test_backpressure();
        test_saturation();
        test_clr_coincident();
        test_reset_mid();
`ifdef PARITY_CHECK_DROP_ERR_EN
        test_drop();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
